auth_pwr_ctrl: RTL and testbench



---
 rtl/auth_pkg.sv | 26 ++
 rtl/uart_rx.sv | 70 +++++++
 rtl/auth_pwr_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_auth_pwr_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/auth_pkg.sv
// Shared types and constants for the rider-authentication / power-enable controller.
package auth_pkg;

   // Controller states; the unused encodings are caught by the FSM default branch.
   typedef enum logic [2:0] {
      S_OFF     = 3'd0,
      S_KEY     = 3'd1,
      S_LOCKOUT = 3'd2,
      S_PWR     = 3'd3,
      S_PARK    = 3'd4
   } state_t;

   // Default command bytes received over the Bluetooth UART.
   localparam logic [7:0] STOP_CMD_DEF   = 8'h73;   // 's'
   localparam logic [7:0] RESUME_CMD_DEF = 8'h67;   // 'g'

   // Larger of two unsigned values, used to size the shared timer.
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      if (a > b) begin
         max_u = a;
      end else begin
         max_u = b;
      end
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: double-flop synchroniser, mid-bit sampling, rdy held until clr_rdy.
module uart_rx #(
   parameter int unsigned BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy
);

   localparam int unsigned CNT_W = $clog2(BAUD_DIV);
   localparam int unsigned HALF  = BAUD_DIV / 2;

   logic             rx_meta_q;
   logic             rx_sync_q;
   logic             busy_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       bit_q;
   logic [9:0]       shift_q;
   logic [7:0]       data_q;
   logic             rdy_q;

   // Synchronise RX, detect the start bit and sample start, data and stop bits mid-bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
         bit_q     <= 4'd0;
         shift_q   <= 10'd0;
         data_q    <= 8'd0;
         rdy_q     <= 1'b0;
      end else begin
         rx_meta_q <= RX;
         rx_sync_q <= rx_meta_q;
         if (!busy_q) begin
            if (!rx_sync_q) begin
               busy_q <= 1'b1;
               cnt_q  <= CNT_W'(HALF - 1);
               bit_q  <= 4'd0;
            end
         end else if (cnt_q == '0) begin
            cnt_q   <= CNT_W'(BAUD_DIV - 1);
            shift_q <= {rx_sync_q, shift_q[9:1]};
            if (bit_q == 4'd9) begin
               // Stop-bit slot: the nine earlier samples hold {d7..d0, start}.
               busy_q <= 1'b0;
               data_q <= shift_q[9:2];
            end else begin
               bit_q <= bit_q + 4'd1;
            end
         end else begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
         // A freshly completed byte takes precedence over a pending clear.
         if (busy_q && (cnt_q == '0) && (bit_q == 4'd9)) begin
            rdy_q <= 1'b1;
         end else if (clr_rdy) begin
            rdy_q <= 1'b0;
         end
      end
   end

   assign rx_data = data_q;
   assign rdy     = rdy_q;

endmodule

// File: rtl/auth_pwr_ctrl.sv
// Rider authentication and power-enable controller: multi-byte unlock key with per-byte
// timeout, failed-attempt lockout, and debounced rider-off power-down while parked.
module auth_pwr_ctrl import auth_pkg::*; #(
   parameter int unsigned              KEY_LEN      = 2,
   parameter logic [8*KEY_LEN-1:0]     KEY          = 16'h4B21,
   parameter logic [7:0]               STOP_CMD     = STOP_CMD_DEF,
   parameter logic [7:0]               RESUME_CMD   = RESUME_CMD_DEF,
   parameter int unsigned              IDLE_TMO_CYC = 50_000_000,
   parameter int unsigned              OFF_DLY_CYC  = 25_000_000,
   parameter int unsigned              MAX_FAIL     = 3,
   parameter int unsigned              LOCK_CYC     = 500_000_000,
   parameter int unsigned              BAUD_DIV     = 2604
) (
   input  logic clk,
   input  logic rst_n,
   input  logic RX,
   input  logic rider_off,
   output logic pwr_up,
   output logic locked,
   output logic auth_err
);

   localparam int unsigned TMR_W  = $clog2(max_u(IDLE_TMO_CYC, max_u(OFF_DLY_CYC, LOCK_CYC)));
   localparam int unsigned IDX_W  = $clog2(KEY_LEN) + 1;
   localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [FAIL_W-1:0]  fail_q, fail_d;
   logic               auth_err_q;
   logic               fail_s;
   logic               rx_rdy_s;
   logic               clr_rdy_s;
   logic [7:0]         rx_data_s;

   // Key byte i, first byte sent taken from the most significant end of KEY.
   function automatic logic [7:0] key_byte(input logic [IDX_W-1:0] i);
      key_byte = 8'h00;
      for (int b = 0; b < int'(KEY_LEN); b++) begin
         if (i == IDX_W'(b)) begin
            key_byte = KEY[8*(int'(KEY_LEN)-1-b) +: 8];
         end else begin
            key_byte = key_byte;
         end
      end
   endfunction

   uart_rx #(
      .BAUD_DIV (BAUD_DIV)
   ) u_uart_rx (
      .clk     (clk),
      .rst_n   (rst_n),
      .RX      (RX),
      .clr_rdy (clr_rdy_s),
      .rx_data (rx_data_s),
      .rdy     (rx_rdy_s)
   );

   // Every byte is consumed in the cycle it is presented, whatever the state does with it.
   assign clr_rdy_s = rx_rdy_s;

   // State register, shared timer, key index, failure counter and the failure pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_OFF;
         timer_q    <= '0;
         idx_q      <= '0;
         fail_q     <= '0;
         auth_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         idx_q      <= idx_d;
         fail_q     <= fail_d;
         auth_err_q <= fail_s;
      end
   end

   // Next-state, counter and failure-event decode.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      fail_d  = fail_q;
      fail_s  = 1'b0;

      case (state_q)
         S_OFF: begin
            timer_d = '0;
            idx_d   = '0;
            if (rx_rdy_s && !rider_off) begin
               if (rx_data_s == key_byte(IDX_W'(0))) begin
                  if (KEY_LEN == 1) begin
                     state_d = S_PWR;
                     fail_d  = '0;
                  end else begin
                     state_d = S_KEY;
                     idx_d   = IDX_W'(1);
                  end
               end else begin
                  fail_s = 1'b1;
               end
            end else begin
               // Bytes arriving with nobody on board are discarded without penalty.
               state_d = S_OFF;
            end
         end

         S_KEY: begin
            if (rider_off) begin
               state_d = S_OFF;
               idx_d   = '0;
            end else if (rx_rdy_s) begin
               if (rx_data_s == key_byte(idx_q)) begin
                  if (idx_q == IDX_W'(KEY_LEN - 1)) begin
                     state_d = S_PWR;
                     idx_d   = '0;
                     fail_d  = '0;
                  end else begin
                     idx_d   = idx_q + IDX_W'(1);
                     timer_d = '0;
                  end
               end else begin
                  fail_s = 1'b1;
               end
            end else if (timer_q == TMR_W'(IDLE_TMO_CYC - 1)) begin
               fail_s = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         S_LOCKOUT: begin
            if (timer_q == TMR_W'(LOCK_CYC - 1)) begin
               state_d = S_OFF;
               fail_d  = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         S_PWR: begin
            if (rx_rdy_s && (rx_data_s == STOP_CMD)) begin
               if (rider_off) begin
                  state_d = S_OFF;
               end else begin
                  state_d = S_PARK;
               end
            end else begin
               state_d = S_PWR;
            end
         end

         S_PARK: begin
            // Resume is checked first so it beats a simultaneous rider-off expiry.
            if (rx_rdy_s && (rx_data_s == RESUME_CMD)) begin
               state_d = S_PWR;
            end else if (rider_off) begin
               if (timer_q == TMR_W'(OFF_DLY_CYC - 1)) begin
                  state_d = S_OFF;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end else begin
               timer_d = '0;
            end
         end

         default: begin
            state_d = S_OFF;
            timer_d = '0;
            idx_d   = '0;
         end
      endcase

      // A failure abandons any key in progress; reaching MAX_FAIL attempts locks out.
      if (fail_s) begin
         idx_d = '0;
         if (fail_q != {FAIL_W{1'b1}}) begin
            fail_d = fail_q + FAIL_W'(1);
         end else begin
            fail_d = fail_q;
         end
         if (fail_q >= FAIL_W'(MAX_FAIL - 1)) begin
            state_d = S_LOCKOUT;
         end else begin
            state_d = S_OFF;
         end
      end else begin
         fail_d = fail_d;
      end

      timer_d = (state_d != state_q) ? '0 : timer_d;
   end

   assign pwr_up   = (state_q == S_PWR) || (state_q == S_PARK);
   assign locked   = (state_q == S_LOCKOUT);
   assign auth_err = auth_err_q;

endmodule

// File: tb/tb_auth_pwr_ctrl.sv
// Directed bench for auth_pwr_ctrl: bytes are sent serially on RX at 16 clocks per bit.
module tb_auth_pwr_ctrl;

   localparam int BIT_CYC = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic RX = 1'b1;
   logic rider_off = 1'b0;
   logic pwr_up;
   logic locked;
   logic auth_err;

   int n_checks = 0;
   int n_pass   = 0;
   int err_pulses = 0;

   typedef struct {
      logic       ro;
      logic [7:0] data;
      logic       exp_pwr;
      logic       exp_lock;
      int         exp_errs;
   } vec_t;

   vec_t vecs [12];

   auth_pwr_ctrl #(
      .IDLE_TMO_CYC (1000),
      .OFF_DLY_CYC  (500),
      .MAX_FAIL     (2),
      .LOCK_CYC     (2000),
      .BAUD_DIV     (BIT_CYC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .RX        (RX),
      .rider_off (rider_off),
      .pwr_up    (pwr_up),
      .locked    (locked),
      .auth_err  (auth_err)
   );

   always #5 clk = ~clk;

   // Count every clock cycle in which the failure pulse is high.
   always @(negedge clk) begin
      if (auth_err === 1'b1) err_pulses <= err_pulses + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Send one 8N1 frame; the stop bit is held for 'tail' cycles.
   task automatic send_byte(input logic [7:0] b, input int tail);
      RX = 1'b0;
      tick(BIT_CYC);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         tick(BIT_CYC);
      end
      RX = 1'b1;
      tick(tail);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   initial begin
      vecs[0]  = '{1'b0, 8'h55, 1'b1, 1'b0, 0};  // other byte ignored in PWR
      vecs[1]  = '{1'b1, 8'h67, 1'b1, 1'b0, 0};  // rider_off alone keeps power
      vecs[2]  = '{1'b1, 8'h73, 1'b0, 1'b0, 0};  // stop with rider off -> OFF
      vecs[3]  = '{1'b1, 8'h4B, 1'b0, 1'b0, 0};  // rider off: key ignored
      vecs[4]  = '{1'b1, 8'h21, 1'b0, 1'b0, 0};
      vecs[5]  = '{1'b0, 8'h21, 1'b0, 1'b0, 1};  // non-key byte in OFF -> failure
      vecs[6]  = '{1'b0, 8'h4B, 1'b0, 1'b0, 1};  // first key byte
      vecs[7]  = '{1'b1, 8'h21, 1'b0, 1'b0, 1};  // rider_off aborts key, no failure
      vecs[8]  = '{1'b0, 8'h4B, 1'b0, 1'b0, 1};
      vecs[9]  = '{1'b0, 8'h21, 1'b1, 1'b0, 1};  // unlock, fail count cleared
      vecs[10] = '{1'b0, 8'h73, 1'b1, 1'b0, 1};  // park with rider on
      vecs[11] = '{1'b0, 8'h67, 1'b1, 1'b0, 1};  // resume

      // Reset values
      tick(3);
      check("reset_pwr_up", pwr_up, 1'b0);
      check("reset_locked", locked, 1'b0);
      check("reset_auth_err", auth_err, 1'b0);
      rst_n = 1'b1;
      tick(3);

      // Unlock with rider on; power rises the cycle after the final byte is ready
      rider_off = 1'b0;
      send_byte(8'h4B, BIT_CYC);
      check("unlock_first_byte_pwr", pwr_up, 1'b0);
      send_byte(8'h21, 11);
      check("unlock_pwr_before", pwr_up, 1'b0);
      tick(1);
      check("unlock_pwr_after", pwr_up, 1'b1);
      tick(4);
      check("unlock_no_err", err_pulses, 0);

      // Table of single-byte transactions
      for (int v = 0; v < 12; v++) begin
         rider_off = vecs[v].ro;
         tick(2);
         send_byte(vecs[v].data, BIT_CYC);
         tick(2);
         check($sformatf("vec%0d_pwr_up", v), pwr_up, vecs[v].exp_pwr);
         check($sformatf("vec%0d_locked", v), locked, vecs[v].exp_lock);
         check($sformatf("vec%0d_errs", v), err_pulses, vecs[v].exp_errs);
      end

      // Park debounce: 499 cycles of rider_off then a gap keep power; 500 drop it
      rider_off = 1'b0;
      tick(2);
      send_byte(8'h73, BIT_CYC);
      check("park_pwr", pwr_up, 1'b1);
      rider_off = 1'b1;
      tick(499);
      rider_off = 1'b0;
      tick(2);
      check("park_499_pwr", pwr_up, 1'b1);
      rider_off = 1'b1;
      tick(499);
      check("park_hold_499_pwr", pwr_up, 1'b1);
      tick(1);
      check("park_hold_500_pwr", pwr_up, 1'b0);

      // Resume arriving in the same cycle the park timer expires
      rider_off = 1'b0;
      tick(2);
      send_byte(8'h4B, BIT_CYC);
      send_byte(8'h21, BIT_CYC);
      send_byte(8'h73, BIT_CYC);
      rider_off = 1'b1;
      tick(344);
      send_byte(8'h67, BIT_CYC);
      check("resume_wins_pwr", pwr_up, 1'b1);
      tick(600);
      check("resume_state_pwr", pwr_up, 1'b1);

      // Key timeout, then wrong byte -> lockout; key ignored while locked
      send_byte(8'h73, BIT_CYC);
      check("stop_to_off_pwr", pwr_up, 1'b0);
      rider_off = 1'b0;
      tick(2);
      send_byte(8'h4B, BIT_CYC);
      tick(995);
      check("tmo_before_err", auth_err, 1'b0);
      tick(1);
      check("tmo_err_pulse", auth_err, 1'b1);
      tick(1);
      check("tmo_err_width", auth_err, 1'b0);
      check("tmo_errs", err_pulses, 2);
      check("tmo_not_locked", locked, 1'b0);
      send_byte(8'h4B, BIT_CYC);
      send_byte(8'h55, BIT_CYC);
      check("lock_locked", locked, 1'b1);
      check("lock_errs", err_pulses, 3);
      send_byte(8'h4B, BIT_CYC);
      send_byte(8'h21, BIT_CYC);
      check("lock_key_ignored_pwr", pwr_up, 1'b0);
      check("lock_key_ignored_locked", locked, 1'b1);
      tick(1675);
      check("lock_last_cycle", locked, 1'b1);
      tick(1);
      check("lock_released", locked, 1'b0);
      check("lock_release_errs", err_pulses, 3);

      // Reset in the middle of a key
      tick(2);
      send_byte(8'h4B, BIT_CYC);
      tick(5);
      rst_n = 1'b0;
      #1;
      check("midkey_rst_pwr", pwr_up, 1'b0);
      tick(3);
      rst_n = 1'b1;
      tick(2);
      send_byte(8'h21, BIT_CYC);
      check("midkey_second_byte_err", err_pulses, 4);
      check("midkey_pwr", pwr_up, 1'b0);
      check("midkey_not_locked", locked, 1'b0);

      // Reset in the middle of a lockout
      tick(2);
      send_byte(8'h55, BIT_CYC);
      check("lock2_locked", locked, 1'b1);
      rst_n = 1'b0;
      #1;
      check("lock2_rst_locked", locked, 1'b0);
      tick(3);
      rst_n = 1'b1;
      tick(2);
      send_byte(8'h4B, BIT_CYC);
      send_byte(8'h21, BIT_CYC);
      check("lock2_unlock_pwr", pwr_up, 1'b1);
      check("lock2_errs", err_pulses, 5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
